uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Receives a framed program image byte-by-byte from the op_uart RX path, packs bytes into
//  WORD_BYTES-wide little-endian words and writes them into the fwrisc program memory.
//  Frame: MAGIC, LEN_LO, LEN_HI (payload length in bytes), payload, CSUM (8-bit sum of payload).
//  Optional per-byte ACK back over op_uart TX gives host-side flow control.
// PARAMETERS
//  WORD_BYTES   4         bytes per memory word (1,2,4)
//  MEM_WORDS    1024      program memory depth in words; ADDR_W = $clog2(MEM_WORDS) localparam
//  ACK_MODE     1         1: send ACK_BYTE after every accepted byte; 0: streaming, no ACKs
//  MAGIC        8'hA5     frame start byte
//  ACK_BYTE     8'h06     per-byte acknowledge; NAK_BYTE 8'h15 sent on checksum/timeout error
//  TIMEOUT_CYC  500000    max sys_clk cycles between bytes inside a frame
// PORTS
//  sys_clk            in   1                 clock (the only clock)
//  sys_rst            in   1                 reset, asynchronous, active-high
//  start              in   1                 pulse: re-arm loader, clear status flags
//  rx_valid           in   1                 one-cycle strobe, rx_data holds received byte
//  rx_data            in   8                 received byte
//  tx_busy            in   1                 op_uart transmitter busy
//  tx_req             out  1                 one-cycle strobe, tx_data to be sent
//  tx_data            out  8                 ACK_BYTE / NAK_BYTE
//  mem_we             out  1                 word write strobe
//  mem_addr           out  ADDR_W            word address
//  mem_wdata          out  8*WORD_BYTES      packed word
//  program_receiving  out  1                 high from MAGIC accepted until DONE/ERR
//  program_done       out  1                 sticky: frame complete, checksum good
//  program_ov         out  1                 sticky: LEN exceeds MEM_WORDS*WORD_BYTES
//  program_err        out  1                 sticky: checksum mismatch or timeout
//  byte_count         out  16                payload bytes accepted in current frame
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; checksum, word buffer, counters 0.
//  - States: IDLE -> LEN_LO -> LEN_HI -> PAYLOAD -> CSUM -> DONE | ERR.
//    IDLE: bytes != MAGIC ignored; MAGIC -> LEN_LO, program_receiving=1.
//    LEN_HI: LEN==0 -> CSUM (expected 0); else PAYLOAD. LEN>capacity sets program_ov.
//    PAYLOAD: each byte -> sum += byte (mod 256), lane byte_count%WORD_BYTES of buffer, byte_count++.
//    CSUM: byte==sum -> DONE (program_done=1); else ERR (program_err=1, NAK).
//    DONE/ERR: program_receiving=0; all rx bytes ignored until start.
//  - start in any state: -> IDLE, clears done/ov/err/byte_count/sum/buffer. start has priority
//    over a same-cycle rx_valid (byte dropped).
//  - Word write: mem_we pulses the cycle after the byte filling lane WORD_BYTES-1 is accepted,
//    mem_addr = word index (starting at 0), mem_wdata = packed word. Final partial word flushed
//    zero-padded the cycle after the last payload byte. No write when word index >= MEM_WORDS
//    (overflowing bytes still checksummed and counted; program_ov stays set; DONE still reachable).
//  - ACK (ACK_MODE=1): every accepted frame byte (LEN_LO..CSUM) queues ACK; CSUM mismatch queues NAK
//    instead. tx_req asserted for one cycle on the first cycle with a queued byte and tx_busy=0.
//    Single-entry queue; a new ACK while one is queued overwrites nothing and is dropped.
//    NAK always overwrites a queued ACK.
//  - Timeout: counter cleared on each accepted byte, runs in LEN_LO..CSUM; reaching TIMEOUT_CYC
//    -> ERR, program_err=1, NAK queued (ACK_MODE=1). No partial word flush on timeout.
//  - byte_count saturates at 16'hFFFF.
// STRUCTURE
//  - Package uart_prog_pkg: state enum, MAGIC/ACK_BYTE/NAK_BYTE defaults, frame-field constants.
//  - One sub-module: uart_prog_packer (byte lane steering, flush, mem write strobe/address).
//  - FSM, checksum, timeout and ACK queue live in the top.
// TESTING
//  - 8-byte payload 01..08, CSUM 8'h24, WORD_BYTES=4 -> writes 32'h04030201@0, 32'h08070605@1, done=1, 9 ACKs... plus LEN ACKs = 11 total.
//  - 5-byte payload, ok CSUM -> 2nd write 32'h00000005@1 (zero pad), done=1.
//  - Wrong CSUM -> program_err=1, done=0, last tx_data=8'h15.
//  - MEM_WORDS=2, LEN=12 -> only addr 0,1 written, program_ov=1, good CSUM still gives done=1.
//  - Stall 10 cycles past TIMEOUT_CYC mid-payload -> program_err=1, receiving=0, NAK sent.
//  - tx_busy held high across 3 accepted bytes -> exactly one tx_req once tx_busy drops; sys_rst mid-frame -> all outputs 0, IDLE.

Source files
------------

// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// Frame layout: MAGIC, LEN_LO, LEN_HI, payload, CSUM.
package uart_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0]  DEF_MAGIC = 8'hA5;
    localparam logic [7:0]  DEF_ACK   = 8'h06;
    localparam logic [7:0]  DEF_NAK   = 8'h15;
    localparam int          LEN_W     = 16;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_prog_packer.sv
// Packs payload bytes little-endian into memory words and issues
// one write strobe per full word, plus a zero-padded final flush.
module uart_prog_packer
    import uart_prog_pkg::*;
#(
    parameter  int WORD_BYTES = 4,
    parameter  int MEM_WORDS  = 1024,
    localparam int ADDR_W     = clog2_min1(MEM_WORDS),
    localparam int DATA_W     = 8 * WORD_BYTES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic              i_last,
    input  logic [7:0]        i_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    localparam int LANE_W = clog2_min1(WORD_BYTES);

    logic [LANE_W-1:0] r_lane;
    logic [DATA_W-1:0] r_buf;
    logic [15:0]       r_widx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [DATA_W-1:0] w_word;
    logic              w_full;
    logic              w_in_range;

    always_comb begin
        w_word = r_buf;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_word[i*8 +: 8] = i_data;
            end
        end
    end

    assign w_full     = (r_lane == LANE_W'(WORD_BYTES - 1));
    assign w_in_range = ({16'd0, r_widx} < 32'(MEM_WORDS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane  <= '0;
            r_buf   <= '0;
            r_widx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_lane <= '0;
                r_buf  <= '0;
                r_widx <= '0;
            end else if (i_valid) begin
                if (w_full || i_last) begin
                    // Words past the end of memory are dropped silently.
                    if (w_in_range) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_widx[ADDR_W-1:0];
                        r_wdata <= w_word;
                    end
                    r_buf  <= '0;
                    r_lane <= '0;
                    if (r_widx != 16'hFFFF) begin
                        r_widx <= r_widx + 16'd1;
                    end
                end else begin
                    r_buf  <= w_word;
                    r_lane <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/uart_prog_loader.sv
// Framed program-image loader: UART RX bytes -> program memory words,
// with checksum, inter-byte timeout and optional per-byte ACK/NAK.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter  int         WORD_BYTES  = 4,
    parameter  int         MEM_WORDS   = 1024,
    parameter  int         ACK_MODE    = 1,
    parameter  logic [7:0] MAGIC       = DEF_MAGIC,
    parameter  logic [7:0] ACK_BYTE    = DEF_ACK,
    parameter  logic [7:0] NAK_BYTE    = DEF_NAK,
    parameter  int         TIMEOUT_CYC = 500000,
    localparam int         ADDR_W      = clog2_min1(MEM_WORDS),
    localparam int         DATA_W      = 8 * WORD_BYTES
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_busy,
    output logic              o_tx_req,
    output logic [7:0]        o_tx_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_program_receiving,
    output logic              o_program_done,
    output logic              o_program_ov,
    output logic              o_program_err,
    output logic [15:0]       o_byte_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CAP   = MEM_WORDS * WORD_BYTES;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_sum;
    logic [15:0]        r_byte_count;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_receiving;
    logic               r_done;
    logic               r_ov;
    logic               r_err;
    logic               r_q_valid;
    logic [7:0]         r_q_data;
    logic               r_tx_req;
    logic [7:0]         r_tx_data;

    logic               w_rx;
    logic [LEN_W-1:0]   w_len;
    logic               w_last;
    logic               w_pay_acc;
    logic               w_in_frame;
    logic               w_tmo_ev;
    logic               w_sum_ok;
    logic               w_ack_push;
    logic               w_nak_push;

    // start wins over a same-cycle byte, which is then dropped.
    assign w_rx       = i_rx_valid && !i_start;
    assign w_len      = {i_rx_data, r_len[7:0]};
    assign w_last     = (r_byte_count == r_len - 16'd1);
    assign w_pay_acc  = w_rx && (r_state == ST_PAYLOAD);
    assign w_in_frame = r_state inside {ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_CSUM};
    assign w_sum_ok   = (i_rx_data == r_sum);
    assign w_tmo_ev   = !i_start && !i_rx_valid && w_in_frame
                      && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    assign w_ack_push = (ACK_MODE != 0) && w_rx
                      && ((r_state inside {ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD})
                      || (r_state == ST_CSUM && w_sum_ok));
    assign w_nak_push = (ACK_MODE != 0)
                      && ((w_rx && r_state == ST_CSUM && !w_sum_ok) || w_tmo_ev);

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_sum        <= '0;
            r_byte_count <= '0;
            r_tmo        <= '0;
            r_receiving  <= 1'b0;
            r_done       <= 1'b0;
            r_ov         <= 1'b0;
            r_err        <= 1'b0;
        end else if (i_start) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_sum        <= '0;
            r_byte_count <= '0;
            r_tmo        <= '0;
            r_receiving  <= 1'b0;
            r_done       <= 1'b0;
            r_ov         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (i_rx_valid) begin
                r_tmo <= '0;
            end else if (w_in_frame && !w_tmo_ev) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid && i_rx_data == MAGIC) begin
                        r_state     <= ST_LEN_LO;
                        r_receiving <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (i_rx_valid) begin
                        r_len[7:0] <= i_rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (i_rx_valid) begin
                        r_len[15:8] <= i_rx_data;
                        if (32'(w_len) > CAP) begin
                            r_ov <= 1'b1;
                        end
                        r_state <= (w_len == '0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_rx_valid) begin
                        r_sum <= r_sum + i_rx_data;
                        if (r_byte_count != COUNT_MAX) begin
                            r_byte_count <= r_byte_count + 16'd1;
                        end
                        if (w_last) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (i_rx_valid) begin
                        r_receiving <= 1'b0;
                        if (w_sum_ok) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_tmo_ev) begin
                r_state     <= ST_ERR;
                r_err       <= 1'b1;
                r_receiving <= 1'b0;
            end
        end
    end

    // Single-slot reply queue; NAK replaces a pending ACK, ACK never queues twice.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_req <= 1'b0;
            if (r_q_valid && !i_tx_busy) begin
                r_tx_req  <= 1'b1;
                r_tx_data <= r_q_data;
                r_q_valid <= 1'b0;
            end
            if (w_nak_push) begin
                r_q_valid <= 1'b1;
                r_q_data  <= NAK_BYTE;
            end else if (w_ack_push && !r_q_valid) begin
                r_q_valid <= 1'b1;
                r_q_data  <= ACK_BYTE;
            end
        end
    end

    uart_prog_packer #(
        .WORD_BYTES (WORD_BYTES),
        .MEM_WORDS  (MEM_WORDS)
    ) u_packer (
        .i_clk       (i_sys_clk),
        .i_rst       (i_sys_rst),
        .i_clear     (i_start),
        .i_valid     (w_pay_acc),
        .i_last      (w_last),
        .i_data      (i_rx_data),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata)
    );

    assign o_tx_req            = r_tx_req;
    assign o_tx_data           = r_tx_data;
    assign o_program_receiving = r_receiving;
    assign o_program_done      = r_done;
    assign o_program_ov        = r_ov;
    assign o_program_err       = r_err;
    assign o_byte_count        = r_byte_count;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: frame table plus corner sequences.
module tb_uart_prog_loader;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        tx_busy = 1'b0;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        mem_we;
    logic [0:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        receiving;
    logic        done;
    logic        ov;
    logic        err;
    logic [15:0] byte_count;

    int checks = 0;
    int failures = 0;

    int          tx_cnt = 0;
    logic [7:0]  last_tx = '0;
    int          wr_n = 0;
    int          wr_addr [64] = '{default: 0};
    logic [31:0] wr_data [64] = '{default: '0};

    uart_prog_loader #(
        .WORD_BYTES  (4),
        .MEM_WORDS   (2),
        .ACK_MODE    (1),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_sys_clk           (clk),
        .i_sys_rst           (rst),
        .i_start             (start),
        .i_rx_valid          (rx_valid),
        .i_rx_data           (rx_data),
        .i_tx_busy           (tx_busy),
        .o_tx_req            (tx_req),
        .o_tx_data           (tx_data),
        .o_mem_we            (mem_we),
        .o_mem_addr          (mem_addr),
        .o_mem_wdata         (mem_wdata),
        .o_program_receiving (receiving),
        .o_program_done      (done),
        .o_program_ov        (ov),
        .o_program_err       (err),
        .o_byte_count        (byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_req) begin
            tx_cnt++;
            last_tx = tx_data;
        end
        if (mem_we && wr_n < 64) begin
            wr_addr[wr_n] = int'(mem_addr);
            wr_data[wr_n] = mem_wdata;
            wr_n++;
        end
    end

    typedef struct {
        string       name;
        int          len;
        logic [7:0]  base;
        logic [7:0]  csum;
        logic        done;
        logic        err;
        logic        ov;
        int          nwr;
        int          a0;
        logic [31:0] w0;
        int          a1;
        logic [31:0] w1;
        int          ntx;
        logic [7:0]  last;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int len, input logic [7:0] base, input logic [7:0] cs);
        logic [15:0] l;
        l = 16'(len);
        send(8'hA5);
        send(l[7:0]);
        send(l[15:8]);
        for (int i = 0; i < len; i++) begin
            send(base + 8'(i));
        end
        send(cs);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".receiving"}, 32'(receiving), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".ov"}, 32'(ov), 0);
        chk({tag, ".err"}, 32'(err), 0);
        chk({tag, ".tx_req"}, 32'(tx_req), 0);
        chk({tag, ".tx_data"}, 32'(tx_data), 0);
        chk({tag, ".mem_we"}, 32'(mem_we), 0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".byte_count"}, 32'(byte_count), 0);
    endtask

    initial begin
        int tb;
        int wb;

        vecs[0] = '{"len8", 8, 8'h01, 8'h24, 1, 0, 0, 2,
                    0, 32'h04030201, 1, 32'h08070605, 11, 8'h06, 16'd8};
        vecs[1] = '{"len5", 5, 8'h01, 8'h0F, 1, 0, 0, 2,
                    0, 32'h04030201, 1, 32'h00000005, 8, 8'h06, 16'd5};
        vecs[2] = '{"badsum", 4, 8'h10, 8'h47, 0, 1, 0, 1,
                    0, 32'h13121110, 0, 32'h0, 7, 8'h15, 16'd4};
        vecs[3] = '{"ovf12", 12, 8'h01, 8'h4E, 1, 0, 1, 2,
                    0, 32'h04030201, 1, 32'h08070605, 15, 8'h06, 16'd12};
        vecs[4] = '{"len0", 0, 8'h00, 8'h00, 1, 0, 0, 0,
                    0, 32'h0, 0, 32'h0, 3, 8'h06, 16'd0};
        vecs[5] = '{"len3wrap", 3, 8'hF0, 8'hD3, 1, 0, 0, 1,
                    0, 32'h00F2F1F0, 0, 32'h0, 6, 8'h06, 16'd3};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        pulse_start();
        tb = tx_cnt;
        send(8'h00);
        send(8'h55);
        chk("idle_ignore.receiving", 32'(receiving), 0);
        chk("idle_ignore.tx", 32'(tx_cnt - tb), 0);

        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("start_prio.receiving", 32'(receiving), 0);

        for (int k = 0; k < 6; k++) begin
            pulse_start();
            tb = tx_cnt;
            wb = wr_n;
            run_frame(vecs[k].len, vecs[k].base, vecs[k].csum);
            repeat (4) @(posedge clk);
            #1;
            chk({vecs[k].name, ".done"}, 32'(done), 32'(vecs[k].done));
            chk({vecs[k].name, ".err"}, 32'(err), 32'(vecs[k].err));
            chk({vecs[k].name, ".ov"}, 32'(ov), 32'(vecs[k].ov));
            chk({vecs[k].name, ".receiving"}, 32'(receiving), 0);
            chk({vecs[k].name, ".count"}, 32'(byte_count), 32'(vecs[k].cnt));
            chk({vecs[k].name, ".nwr"}, 32'(wr_n - wb), 32'(vecs[k].nwr));
            chk({vecs[k].name, ".a0"}, 32'(wr_addr[wb]), 32'(vecs[k].a0));
            chk({vecs[k].name, ".w0"}, wr_data[wb], vecs[k].w0);
            chk({vecs[k].name, ".a1"}, 32'(wr_addr[wb+1]), 32'(vecs[k].a1));
            chk({vecs[k].name, ".w1"}, wr_data[wb+1], vecs[k].w1);
            chk({vecs[k].name, ".ntx"}, 32'(tx_cnt - tb), 32'(vecs[k].ntx));
            chk({vecs[k].name, ".last_tx"}, 32'(last_tx), 32'(vecs[k].last));
        end

        tb = tx_cnt;
        send(8'hA5);
        send(8'h02);
        chk("done_ignore.receiving", 32'(receiving), 0);
        chk("done_ignore.done", 32'(done), 1);
        chk("done_ignore.tx", 32'(tx_cnt - tb), 0);

        pulse_start();
        tb = tx_cnt;
        wb = wr_n;
        send(8'hA5);
        send(8'h08);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        chk("tmo.pre_receiving", 32'(receiving), 1);
        chk("tmo.pre_count", 32'(byte_count), 2);
        repeat (TMO + 10) @(posedge clk);
        #1;
        chk("tmo.err", 32'(err), 1);
        chk("tmo.receiving", 32'(receiving), 0);
        chk("tmo.done", 32'(done), 0);
        chk("tmo.last_tx", 32'(last_tx), 32'h15);
        chk("tmo.ntx", 32'(tx_cnt - tb), 5);
        chk("tmo.nwr", 32'(wr_n - wb), 0);

        pulse_start();
        tb = tx_cnt;
        tx_busy = 1'b1;
        send(8'hA5);
        send(8'h03);
        send(8'h00);
        send(8'h77);
        chk("busy.held", 32'(tx_cnt - tb), 0);
        tx_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy.one_req", 32'(tx_cnt - tb), 1);
        chk("busy.last_tx", 32'(last_tx), 32'h06);

        pulse_start();
        send(8'hA5);
        send(8'h08);
        send(8'h00);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("midrst.pre_receiving", 32'(receiving), 1);
        chk("midrst.pre_count", 32'(byte_count), 3);
        rst = 1'b1;
        #2;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h08);
        chk("midrst.idle_receiving", 32'(receiving), 0);
        chk("midrst.idle_count", 32'(byte_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
